// File: rtl/maze_pkg.sv
// Shared encodings and helpers for the depth-first maze controller:
// move directions, controller states and single-step neighbour arithmetic.
package maze_pkg;

   localparam int MAZE_DIM = 16;

   localparam logic [1:0] DIR_U = 2'd0;
   localparam logic [1:0] DIR_R = 2'd1;
   localparam logic [1:0] DIR_L = 2'd2;
   localparam logic [1:0] DIR_D = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_CHK0, S_MARK, S_PROBE, S_POP, S_REPLAY, S_DONE, S_FAIL
   } state_t;

   typedef struct packed {
      logic       ok;
      logic [3:0] x;
      logic [3:0] y;
   } step_t;

   // The encoding is chosen so that U<->D and R<->L are bitwise complements.
   function automatic logic [1:0] opposite(input logic [1:0] d);
      return ~d;
   endfunction

   // ok is low when the step would leave the grid; x/y then hold the wrapped value.
   function automatic step_t step(input logic [3:0] x, input logic [3:0] y,
                                  input logic [1:0] d);
      step_t s;
      s.ok = 1'b1;
      s.x  = x;
      s.y  = y;
      case (d)
         DIR_U: begin s.ok = (y != 4'(MAZE_DIM - 1)); s.y = y + 4'd1; end
         DIR_R: begin s.ok = (x != 4'(MAZE_DIM - 1)); s.x = x + 4'd1; end
         DIR_L: begin s.ok = (x != 4'd0);             s.x = x - 4'd1; end
         default: begin s.ok = (y != 4'd0);           s.y = y - 4'd1; end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/dir_stack.sv
// LIFO of 2-bit moves holding the current DFS path, with an extra indexed
// read port so the finished path can be replayed from the bottom.
module dir_stack #(
   parameter int DEPTH = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [1:0]                   push_dir,
   output logic [1:0]                   top,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   input  logic [$clog2(DEPTH)-1:0]     rd_idx,
   output logic [1:0]                   rd_data
);

   localparam int IW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);

   logic [1:0]    mem [DEPTH];
   logic [NW-1:0] top_ptr;

   assign empty   = (count == '0);
   assign full    = (count == NW'(DEPTH));
   assign top_ptr = count - NW'(1);
   assign top     = mem[top_ptr[IW-1:0]];
   assign rd_data = mem[rd_idx];

   // Entries need no reset; only the fill level defines what is valid.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[count[IW-1:0]] <= push_dir;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + NW'(1);
      end else if (pop && !empty) begin
         count <= count - NW'(1);
      end
   end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// Depth-first rat-in-maze controller: explores the 16x16 maze memory from (0,0),
// marks visited cells, backtracks via dir_stack and streams the solution moves.
module maze_dfs_ctrl
   import maze_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int GOAL_X = 15,
   parameter int GOAL_Y = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [3:0] X,
   output logic [3:0] Y,
   output logic       read,
   output logic       write,
   output logic       d_in,
   input  logic       mode,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic       move_valid,
   input  logic       move_ready,
   output logic [1:0] move_dir
);

   localparam int IW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);

   state_t        state;
   logic [3:0]    cx, cy;
   logic [1:0]    dir;
   logic [IW-1:0] ri;

   logic          push, pop, empty, full, probe_free, at_goal, last_move;
   logic [1:0]    top, rd_data;
   logic [NW-1:0] count;
   logic [IW-1:0] rd_idx;
   step_t         first_probe, next_probe, back_cell, back_probe;

   dir_stack #(.DEPTH(DEPTH)) u_stack (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .push_dir (dir),
      .top      (top),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data)
   );

   // mode is only meaningful while read is high, so every use is gated by read.
   always_comb begin
      probe_free  = (state == S_PROBE) && read && (mode == 1'b0);
      push        = probe_free && !full;
      pop         = (state == S_POP) && !empty;
      first_probe = step(cx, cy, DIR_U);
      next_probe  = step(cx, cy, dir + 2'd1);
      back_cell   = step(cx, cy, opposite(top));
      back_probe  = step(back_cell.x, back_cell.y, top + 2'd1);
      at_goal     = (cx == 4'(GOAL_X)) && (cy == 4'(GOAL_Y));
      last_move   = (NW'(ri) + NW'(1)) == count;
      rd_idx      = (state == S_REPLAY) ? ri + IW'(1) : '0;
   end

   // X/Y/read/write are loaded one cycle ahead so they are valid for the whole state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cx         <= '0;
         cy         <= '0;
         dir        <= DIR_U;
         ri         <= '0;
         X          <= '0;
         Y          <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         d_in       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         move_valid <= 1'b0;
         move_dir   <= DIR_U;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_CHK0;
                  busy  <= 1'b1;
                  read  <= 1'b1;
                  d_in  <= 1'b1;
                  X     <= '0;
                  Y     <= '0;
                  cx    <= '0;
                  cy    <= '0;
               end
            end
            S_CHK0: begin
               read <= 1'b0;
               if (mode == 1'b0) begin
                  state <= S_MARK;
                  write <= 1'b1;
               end else begin
                  state <= S_FAIL;
                  fail  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            S_MARK: begin
               write <= 1'b0;
               if (at_goal && count == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else if (at_goal) begin
                  state      <= S_REPLAY;
                  ri         <= '0;
                  move_valid <= 1'b1;
                  move_dir   <= rd_data;
               end else begin
                  state <= S_PROBE;
                  dir   <= DIR_U;
                  X     <= first_probe.x;
                  Y     <= first_probe.y;
                  read  <= first_probe.ok;
               end
            end
            S_PROBE: begin
               if (probe_free) begin
                  read <= 1'b0;
                  if (full) begin
                     state <= S_FAIL;
                     fail  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_MARK;
                     cx    <= X;
                     cy    <= Y;
                     write <= 1'b1;
                  end
               end else if (dir == DIR_D) begin
                  state <= S_POP;
                  read  <= 1'b0;
                  X     <= cx;
                  Y     <= cy;
               end else begin
                  dir  <= dir + 2'd1;
                  X    <= next_probe.x;
                  Y    <= next_probe.y;
                  read <= next_probe.ok;
               end
            end
            S_POP: begin
               if (empty || !back_cell.ok) begin
                  state <= S_FAIL;
                  fail  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  cx <= back_cell.x;
                  cy <= back_cell.y;
                  if (top == DIR_D) begin
                     X <= back_cell.x;
                     Y <= back_cell.y;
                  end else begin
                     state <= S_PROBE;
                     dir   <= top + 2'd1;
                     X     <= back_probe.x;
                     Y     <= back_probe.y;
                     read  <= back_probe.ok;
                  end
               end
            end
            S_REPLAY: begin
               if (move_ready) begin
                  if (last_move) begin
                     state      <= S_DONE;
                     move_valid <= 1'b0;
                     done       <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     ri       <= ri + IW'(1);
                     move_dir <= rd_data;
                  end
               end
            end
            S_DONE, S_FAIL: begin
               read       <= 1'b0;
               write      <= 1'b0;
               move_valid <= 1'b0;
               busy       <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// Self-checking bench for maze_dfs_ctrl: a behavioural maze memory plus a plain
// DFS reference that predicts the replayed path and the final visited map.
module tb_maze_dfs_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] X, Y;
   logic       read, write, d_in, mode;
   logic       busy, done, fail, move_valid;
   logic       move_ready = 1'b0;
   logic [1:0] move_dir;

   logic [255:0] mazeMem;
   logic [255:0] loadVal;
   logic         loadReq = 1'b0;
   logic         noise = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [1:0]   dutMoves[$];
   logic [1:0]   refPath[$];
   logic [1:0]   goldPath[$];
   logic [255:0] refVisited;
   bit           refFail;

   int rwConflicts, writesSeen, validSeen, bothSeen, dirUnstable, runCycles;
   bit timedOut, busyAtStart;

   maze_dfs_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .X          (X),
      .Y          (Y),
      .read       (read),
      .write      (write),
      .d_in       (d_in),
      .mode       (mode),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .move_dir   (move_dir)
   );

   always #5 clk = ~clk;

   // Maze memory: combinational read, garbage on mode whenever read is low.
   assign mode = read ? mazeMem[{Y, X}] : noise;

   always @(negedge clk) noise <= 1'($urandom_range(0, 1));

   always @(posedge clk) begin
      if (loadReq) mazeMem <= loadVal;
      else if (write) mazeMem[{Y, X}] <= d_in;
   end

   task automatic loadMaze(input logic [255:0] m);
      loadVal = m;
      loadReq = 1'b1;
      @(posedge clk);
      #1 loadReq = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b0;
      start = 1'b0;
      move_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Reference: textbook DFS over the grid, trying U,R,L,D and backtracking.
   task automatic refDfs(input logic [255:0] maze);
      int cx, cy, d, nx, ny;
      bit moved;
      refPath = {};
      refVisited = maze;
      refFail = 0;
      if (maze[0]) begin
         refFail = 1;
         return;
      end
      cx = 0; cy = 0; d = 0;
      refVisited[0] = 1'b1;
      while (!(cx == 15 && cy == 15)) begin
         moved = 0;
         while (d < 4 && !moved) begin
            nx = cx + ((d == 1) ? 1 : (d == 2) ? -1 : 0);
            ny = cy + ((d == 0) ? 1 : (d == 3) ? -1 : 0);
            if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !refVisited[ny*16+nx]) begin
               refPath.push_back(2'(d));
               cx = nx; cy = ny; d = 0; moved = 1;
               refVisited[ny*16+nx] = 1'b1;
            end else begin
               d++;
            end
         end
         if (!moved) begin
            if (refPath.size() == 0) begin
               refFail = 1;
               return;
            end
            d = int'(refPath.pop_back());
            cx = cx - ((d == 1) ? 1 : (d == 2) ? -1 : 0);
            cy = cy - ((d == 0) ? 1 : (d == 3) ? -1 : 0);
            d = d + 1;
         end
      end
   endtask

   function automatic int firstDiff(input int dummy);
      firstDiff = -1;
      for (int i = 0; i < refPath.size(); i++) begin
         if (firstDiff < 0 && (i >= dutMoves.size() || dutMoves[i] !== refPath[i])) firstDiff = i;
      end
      if (firstDiff < 0 && dummy != 0) firstDiff = -1;
   endfunction

   // Pulses start and observes every cycle on the falling edge until done/fail.
   task automatic runDut(input int stallAfter, input bit randReady);
      int accepted = 0, stallCnt = 0;
      bit prevStall = 0;
      logic [1:0] prevDir = 2'd0;
      dutMoves = {};
      rwConflicts = 0; writesSeen = 0; validSeen = 0; bothSeen = 0;
      dirUnstable = 0; timedOut = 0; runCycles = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busyAtStart = busy;
      while (1) begin
         if (read && write) rwConflicts++;
         if (write) writesSeen++;
         if (move_valid) validSeen++;
         if (done && fail) bothSeen++;
         if (prevStall && (move_valid !== 1'b1 || move_dir !== prevDir)) dirUnstable++;
         if (done || fail) break;
         if (runCycles >= 20000) begin
            timedOut = 1;
            break;
         end
         if (stallAfter >= 0 && accepted == stallAfter && stallCnt < 5 && move_valid) begin
            move_ready = 1'b0;
            stallCnt++;
         end else if (randReady) begin
            move_ready = ($urandom_range(0, 3) != 0);
         end else begin
            move_ready = 1'b1;
         end
         if (move_valid && move_ready) begin
            dutMoves.push_back(move_dir);
            accepted++;
         end
         prevStall = move_valid && !move_ready;
         prevDir = move_dir;
         @(negedge clk);
         runCycles++;
      end
      move_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      checks++;
      if ({X, Y, read, write, d_in, busy, done, fail, move_valid, move_dir} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_async outputs=%h expected 0",
                  {X, Y, read, write, d_in, busy, done, fail, move_valid, move_dir});
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({X, Y, read, write, busy, done, fail, move_valid} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_idle outputs=%h expected 0",
                  {X, Y, read, write, busy, done, fail, move_valid});
      end
   endtask

   task automatic test_open_map();
      int d;
      goldPath = {};
      for (int i = 0; i < 15; i++) goldPath.push_back(2'd0);
      for (int i = 0; i < 15; i++) goldPath.push_back(2'd1);
      loadMaze('0);
      doReset();
      refDfs('0);
      runDut(-1, 0);
      checks++;
      if (busyAtStart !== 1'b1) begin
         errors++;
         $display("[TB] FAIL open_busy got %b expected 1", busyAtStart);
      end
      checks++;
      if (done !== 1'b1 || fail !== 1'b0 || timedOut) begin
         errors++;
         $display("[TB] FAIL open_done done=%b fail=%b timeout=%0d expected done=1", done, fail, timedOut);
      end
      checks++;
      if (dutMoves.size() != 30 || refPath.size() != 30) begin
         errors++;
         $display("[TB] FAIL open_len got %0d ref %0d expected 30", dutMoves.size(), refPath.size());
      end
      d = -1;
      for (int i = 0; i < 30; i++) begin
         if (d < 0 && (i >= dutMoves.size() || dutMoves[i] !== goldPath[i])) d = i;
      end
      checks++;
      if (d >= 0) begin
         errors++;
         $display("[TB] FAIL open_path first bad move at %0d expected U x15 then R x15", d);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || move_valid !== 1'b0 || fail !== 1'b0) begin
         errors++;
         $display("[TB] FAIL open_start_ignored done=%b busy=%b valid=%b fail=%b expected 1 0 0 0",
                  done, busy, move_valid, fail);
      end
   endtask

   task automatic test_start_wall();
      logic [255:0] m = '0;
      m[0] = 1'b1;
      loadMaze(m);
      doReset();
      runDut(-1, 0);
      checks++;
      if (fail !== 1'b1 || done !== 1'b0 || runCycles > 2) begin
         errors++;
         $display("[TB] FAIL wall_fail fail=%b done=%b cycles=%0d expected fail within 2", fail, done, runCycles);
      end
      checks++;
      if (writesSeen != 0 || validSeen != 0) begin
         errors++;
         $display("[TB] FAIL wall_quiet writes=%0d valids=%0d expected 0 0", writesSeen, validSeen);
      end
   endtask

   task automatic test_dead_end();
      logic [255:0] m = '1;
      int d;
      for (int y = 0; y <= 5; y++) m[y*16] = 1'b0;
      for (int x = 0; x < 16; x++) m[x] = 1'b0;
      for (int y = 0; y < 16; y++) m[y*16+15] = 1'b0;
      goldPath = {};
      for (int i = 0; i < 15; i++) goldPath.push_back(2'd1);
      for (int i = 0; i < 15; i++) goldPath.push_back(2'd0);
      loadMaze(m);
      doReset();
      refDfs(m);
      runDut(-1, 1);
      checks++;
      if (done !== 1'b1 || timedOut) begin
         errors++;
         $display("[TB] FAIL dead_done done=%b fail=%b expected done", done, fail);
      end
      d = (dutMoves.size() == 30) ? -1 : 99;
      for (int i = 0; i < 30; i++) begin
         if (d < 0 && (dutMoves[i] !== goldPath[i] || refPath[i] !== goldPath[i])) d = i;
      end
      checks++;
      if (d >= 0) begin
         errors++;
         $display("[TB] FAIL dead_path bad at %0d len=%0d expected R x15 then U x15", d, dutMoves.size());
      end
      checks++;
      if ({mazeMem[80], mazeMem[64], mazeMem[48], mazeMem[32], mazeMem[16]} !== 5'b11111) begin
         errors++;
         $display("[TB] FAIL dead_marked got %b expected 11111",
                  {mazeMem[80], mazeMem[64], mazeMem[48], mazeMem[32], mazeMem[16]});
      end
      checks++;
      if (dirUnstable != 0 || rwConflicts != 0) begin
         errors++;
         $display("[TB] FAIL dead_proto unstable=%0d rw=%0d expected 0 0", dirUnstable, rwConflicts);
      end
   endtask

   task automatic test_walled_goal();
      logic [255:0] m = '0;
      m[15*16+14] = 1'b1;
      m[14*16+15] = 1'b1;
      loadMaze(m);
      doReset();
      refDfs(m);
      runDut(-1, 0);
      checks++;
      if (fail !== 1'b1 || done !== 1'b0 || refFail != 1 || validSeen != 0) begin
         errors++;
         $display("[TB] FAIL walled_fail fail=%b done=%b valids=%0d expected fail only", fail, done, validSeen);
      end
      checks++;
      if (mazeMem !== refVisited || $countones(mazeMem) != 255 || mazeMem[255] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL walled_visited ones=%0d expected 255 with goal clear", $countones(mazeMem));
      end
   endtask

   task automatic test_stall();
      loadMaze('0);
      doReset();
      refDfs('0);
      runDut(10, 0);
      checks++;
      if (dutMoves.size() != refPath.size() || firstDiff(0) >= 0) begin
         errors++;
         $display("[TB] FAIL stall_path len=%0d expected %0d first bad %0d",
                  dutMoves.size(), refPath.size(), firstDiff(0));
      end
      checks++;
      if (dirUnstable != 0 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_hold unstable=%0d done=%b expected 0 1", dirUnstable, done);
      end
   endtask

   task automatic test_random();
      logic [255:0] m;
      for (int iter = 0; iter < 6; iter++) begin
         for (int i = 0; i < 256; i++) m[i] = ($urandom_range(0, 99) < 28);
         m[0] = 1'b0;
         m[255] = 1'b0;
         loadMaze(m);
         doReset();
         refDfs(m);
         runDut(-1, 1);
         checks++;
         if (timedOut || done !== !refFail || fail !== refFail) begin
            errors++;
            $display("[TB] FAIL rand%0d_outcome done=%b fail=%b expected fail=%0d", iter, done, fail, refFail);
         end
         checks++;
         if (dutMoves.size() != refPath.size() || firstDiff(0) >= 0) begin
            errors++;
            $display("[TB] FAIL rand%0d_path len=%0d expected %0d first bad %0d",
                     iter, dutMoves.size(), refPath.size(), firstDiff(0));
         end
         checks++;
         if (mazeMem !== refVisited) begin
            errors++;
            $display("[TB] FAIL rand%0d_visited ones=%0d expected %0d",
                     iter, $countones(mazeMem), $countones(refVisited));
         end
         checks++;
         if (rwConflicts != 0 || bothSeen != 0 || dirUnstable != 0) begin
            errors++;
            $display("[TB] FAIL rand%0d_proto rw=%0d both=%0d unstable=%0d expected 0",
                     iter, rwConflicts, bothSeen, dirUnstable);
         end
      end
   endtask

   task automatic test_reset_mid();
      int writes = 0;
      int waited = 0;
      loadMaze('0);
      doReset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!(writes >= 3 && read) && waited < 200) begin
         if (write) writes++;
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= 200) begin
         errors++;
         $display("[TB] FAIL midrst_reach waited=%0d expected a probe read", waited);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({X, Y, read, write, d_in, busy, done, fail, move_valid, move_dir} !== '0) begin
         errors++;
         $display("[TB] FAIL midrst_async outputs=%h expected 0",
                  {X, Y, read, write, d_in, busy, done, fail, move_valid, move_dir});
      end
      @(negedge clk);
      rst = 1'b1;
      loadMaze('0);
      @(negedge clk);
      refDfs('0);
      runDut(-1, 1);
      checks++;
      if (done !== 1'b1 || dutMoves.size() != 30 || firstDiff(0) >= 0) begin
         errors++;
         $display("[TB] FAIL midrst_rerun done=%b len=%0d expected done with 30 moves", done, dutMoves.size());
      end
   endtask

   initial begin
      test_reset();
      test_open_map();
      test_start_wall();
      test_dead_end();
      test_walled_goal();
      test_stall();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
